s3_maxpool: RTL

Stage 3 of the CNN datapath: consumes the 144-entry convolution result array produced by stage 2 and applies 2×2, stride-2 max pooling per filter channel. It produces a 36-entry pooled array of 4 channels × 3×3. On a `start` pulse it walks all windows sequentially, one window per cycle, writes the results to a registered output array, and signals completion with `done`. It sits between the stage-2 convolution/ReLU block and the next stage (dense/flatten).

---
 rtl/s3_maxpool_if.sv | 29 ++
 rtl/s3_maxpool.sv | 124 ++++++++++++
 2 files changed

// File: rtl/s3_maxpool_if.sv
// Stage-3 max-pool bus: start/tensor in, pooled array and status out.
interface s3_maxpool_if #(
  parameter int IWIDTH   = 35,
  parameter int OWIDTH   = 17,
  parameter int CHANNELS = 4,
  parameter int IN_DIM   = 6
);
  localparam int N_IN  = CHANNELS * IN_DIM * IN_DIM;
  localparam int N_OUT = CHANNELS * (IN_DIM / 2) * (IN_DIM / 2);
  localparam int OAW   = $clog2(N_OUT);

  logic                     start;
  logic signed [IWIDTH-1:0] input_tensor [N_IN];
  logic signed [OWIDTH-1:0] output_res   [N_OUT];
  logic                     out_valid;
  logic [OAW-1:0]           out_addr;
  logic                     busy;
  logic                     done;

  modport master (
    output start, input_tensor,
    input  output_res, out_valid, out_addr, busy, done
  );

  modport slave (
    input  start, input_tensor,
    output output_res, out_valid, out_addr, busy, done
  );
endinterface

// File: rtl/s3_maxpool.sv
// Stage 3 of the CNN datapath: 2x2 stride-2 max pooling per channel,
// one window per cycle, results held in a registered output array.
// Optional macro S3_POOL_SAT_EN clamps each pooled value to [0, 2^(OWIDTH-1)-1];
// without it the value is truncated to its low OWIDTH bits.
module s3_maxpool #(
  parameter int IWIDTH   = 35,
  parameter int OWIDTH   = 17,
  parameter int CHANNELS = 4,
  parameter int IN_DIM   = 6
) (
  input  logic         clk,
  input  logic         reset,
  s3_maxpool_if.slave  bus
);
  localparam int OUT_DIM = IN_DIM / 2;
  localparam int N_IN    = CHANNELS * IN_DIM * IN_DIM;
  localparam int N_OUT   = CHANNELS * OUT_DIM * OUT_DIM;
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int IAW     = $clog2(N_IN);
  localparam int OAW     = $clog2(N_OUT);
  localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(OUT_DIM - 1);
`ifdef S3_POOL_SAT_EN
  localparam logic signed [IWIDTH-1:0] SAT_MAX = IWIDTH'((longint'(1) <<< (OWIDTH - 1)) - 1);
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            ch;
  logic [PW-1:0]            prow, pcol;
  logic                     last_win;
  logic [IAW-1:0]           base;
  logic [OAW-1:0]           wr_idx;
  logic signed [IWIDTH-1:0] max_top, max_bot, max_win;
  logic signed [OWIDTH-1:0] pooled;
  logic signed [OWIDTH-1:0] res [N_OUT];
  logic                     run_q;

  assign last_win = (ch == CH_LAST) && (prow == POS_LAST) && (pcol == POS_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_win)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state and counters
  always_comb begin
    run_q        = (state == RUN);
    bus.busy     = run_q;
    bus.out_valid = run_q;
    bus.out_addr = run_q ? wr_idx : '0;
    bus.done     = (state == DONE);
  end

  // Window counters: pcol fastest, then prow, then ch; cleared on entry to RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      ch   <= '0;
      prow <= '0;
      pcol <= '0;
    end else if (state == IDLE && bus.start) begin
      ch   <= '0;
      prow <= '0;
      pcol <= '0;
    end else if (state == RUN) begin
      if (pcol != POS_LAST) begin
        pcol <= pcol + 1'b1;
      end else begin
        pcol <= '0;
        if (prow != POS_LAST) begin
          prow <= prow + 1'b1;
        end else begin
          prow <= '0;
          ch   <= (ch == CH_LAST) ? '0 : ch + 1'b1;
        end
      end
    end
  end

  // Window addressing, two-level compare tree and output reduction
  always_comb begin
    base    = IAW'(ch) * IAW'(IN_DIM * IN_DIM) + IAW'(prow) * IAW'(2 * IN_DIM)
            + IAW'(pcol) * IAW'(2);
    wr_idx  = OAW'(ch) * OAW'(OUT_DIM * OUT_DIM) + OAW'(prow) * OAW'(OUT_DIM) + OAW'(pcol);
    max_top = (bus.input_tensor[base] > bus.input_tensor[base + IAW'(1)])
            ? bus.input_tensor[base] : bus.input_tensor[base + IAW'(1)];
    max_bot = (bus.input_tensor[base + IAW'(IN_DIM)] > bus.input_tensor[base + IAW'(IN_DIM + 1)])
            ? bus.input_tensor[base + IAW'(IN_DIM)] : bus.input_tensor[base + IAW'(IN_DIM + 1)];
    max_win = (max_top > max_bot) ? max_top : max_bot;
`ifdef S3_POOL_SAT_EN
    if (max_win[IWIDTH-1])        pooled = '0;
    else if (max_win > SAT_MAX)   pooled = OWIDTH'(SAT_MAX);
    else                          pooled = OWIDTH'(max_win);
`else
    pooled = OWIDTH'(max_win);
`endif
  end

  // Pooled result array: one entry written per RUN cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_OUT; i++) res[i] <= '0;
    end else if (state == RUN) begin
      res[wr_idx] <= pooled;
    end
  end

  assign bus.output_res = res;

endmodule
